a2d_spi_resp: RTL and testbench



---
 rtl/a2d_spi_resp.sv | 150 +++++++++++++++
 tb/tb_a2d_spi_resp.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D: 16-bit commands in, the previous channel's value out.
// Optional build macro A2D_NOISE_EN adds an 8-bit LFSR dither on the two LSBs of every response.
module a2d_spi_resp #(
  parameter int SCLK_MIN_HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] batt_val,
  input  logic [11:0] curr_val,
  input  logic [11:0] brake_val,
  input  logic [11:0] torque_val,
  output logic        frm_done,
  output logic        frm_err,
  output logic [2:0]  last_chnnl,
  output logic [1:0]  state_dbg
);

  // Handshake: there is no valid/ready pair here; a frame is "offered" by SS_n low
  // and "accepted" only when exactly 16 SCLK rises are seen before SS_n returns high.

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FINISH = 2'd2} state_t;

  if (SCLK_MIN_HALF < 4) begin : g_half_chk
    $error("SCLK_MIN_HALF must be at least 4 clk cycles");
  end

  state_t      state, nxt_state;
  logic        ss_ff1, ss_ff2, ss_ff3;
  logic        sclk_ff1, sclk_ff2, sclk_ff3;
  logic        mosi_ff1, mosi_ff2;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0] tx_shft, rx_shft;
  logic [4:0]  bit_cnt;
  logic        fall_pend;
  logic        load, rx_en, tx_en, good, bad;
  logic [11:0] sel_val, resp_val;

  // Synchronizers are deliberately not reset so a frame already in progress
  // when reset releases produces no false SS_n fall.
  always_ff @(posedge clk) begin
    ss_ff1   <= SS_n;
    ss_ff2   <= ss_ff1;
    ss_ff3   <= ss_ff2;
    sclk_ff1 <= SCLK;
    sclk_ff2 <= sclk_ff1;
    sclk_ff3 <= sclk_ff2;
    mosi_ff1 <= MOSI;
    mosi_ff2 <= mosi_ff1;
  end

  assign ss_fall   = ss_ff3 & ~ss_ff2;
  assign ss_rise   = ~ss_ff3 & ss_ff2;
  assign sclk_rise = ~sclk_ff3 & sclk_ff2 & ~ss_ff2;
  assign sclk_fall = sclk_ff3 & ~sclk_ff2 & ~ss_ff2;

  always_comb begin
    sel_val = 12'h000;
    case (last_chnnl)
      3'd0:    sel_val = batt_val;
      3'd1:    sel_val = curr_val;
      3'd3:    sel_val = brake_val;
      3'd4:    sel_val = torque_val;
      default: sel_val = 12'h000;
    endcase
  end

`ifdef A2D_NOISE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst)       lfsr <= 8'hA5;
    else if (good) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign resp_val = sel_val ^ {10'b0, lfsr[1:0]};
`else
  assign resp_val = sel_val;
`endif

  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    rx_en     = 1'b0;
    tx_en     = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall || fall_pend) begin
          load      = 1'b1;
          nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          nxt_state = FINISH;
        end else begin
          rx_en = sclk_rise;
          // The first SCLK fall only launches bit 15, which is already on MISO.
          tx_en = sclk_fall && (bit_cnt != 5'd0);
        end
      end
      FINISH: begin
        good      = (bit_cnt == 5'd16);
        bad       = (bit_cnt != 5'd16);
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_shft    <= 16'h0000;
      rx_shft    <= 16'h0000;
      bit_cnt    <= 5'd0;
      last_chnnl <= 3'b000;
      frm_done   <= 1'b0;
      frm_err    <= 1'b0;
      fall_pend  <= 1'b0;
      MISO       <= 1'b0;
    end else begin
      state     <= nxt_state;
      frm_done  <= good;
      frm_err   <= bad;
      fall_pend <= (state == FINISH) && ss_fall;
      MISO      <= ~ss_ff2 & tx_shft[15];
      if (load) begin
        tx_shft <= {4'h0, resp_val};
        bit_cnt <= 5'd0;
      end else begin
        if (rx_en) begin
          rx_shft <= {rx_shft[14:0], mosi_ff2};
          if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
        end
        if (tx_en) tx_shft <= {tx_shft[14:0], 1'b0};
      end
      // The channel pointer and last_chnnl are the same register.
      if (good) last_chnnl <= rx_shft[13:11];
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: SPI master driver tasks plus a channel-pointer/LFSR reference model.
// Build with +define+A2D_NOISE_EN to also exercise the dithered responses.
module tb_a2d_spi_resp;

  localparam int HALF = 6;
`ifdef A2D_NOISE_EN
  localparam bit NOISE = 1'b1;
`else
  localparam bit NOISE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] batt_val, curr_val, brake_val, torque_val;
  logic        frm_done, frm_err;
  logic [2:0]  last_chnnl;
  logic [1:0]  state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int err_cnt      = 0;

  logic [2:0] m_ptr;
  logic [7:0] m_lfsr;

  a2d_spi_resp #(.SCLK_MIN_HALF(4)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .batt_val(batt_val), .curr_val(curr_val), .brake_val(brake_val), .torque_val(torque_val),
    .frm_done(frm_done), .frm_err(frm_err), .last_chnnl(last_chnnl), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      done_cnt <= done_cnt + int'(frm_done);
      err_cnt  <= err_cnt + int'(frm_err);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] m_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return batt_val;
      3'd1:    return curr_val;
      3'd3:    return brake_val;
      3'd4:    return torque_val;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [15:0] m_resp();
    logic [11:0] v;
    v = m_val(m_ptr);
    if (NOISE) v = v ^ {10'b0, m_lfsr[1:0]};
    return {4'h0, v};
  endfunction

  task automatic model_reset();
    m_ptr  = 3'd0;
    m_lfsr = 8'hA5;
  endtask

  task automatic model_frame(input logic [15:0] cmd, input int nbits);
    if (nbits == 16) begin
      m_ptr  = cmd[13:11];
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  // ---------------- driver ----------------
  task automatic randomize_vals();
    batt_val   = 12'($urandom_range(0, 4095));
    curr_val   = 12'($urandom_range(0, 4095));
    brake_val  = 12'($urandom_range(0, 4095));
    torque_val = 12'($urandom_range(0, 4095));
  endtask

  // Master: MOSI launched on SCLK fall, MISO sampled at SCLK rise. SS_n then held
  // high for 'hold' clocks; frame-end outputs are captured 4 clocks after SS_n rises.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int hold,
                           input bit perturb, output logic [15:0] resp,
                           output logic d4, output logic e4, output logic [2:0] lc4);
    resp = 16'h0000;
    d4 = 1'bx; e4 = 1'bx; lc4 = 3'bxxx;
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
      wait_clk(HALF);
      if (i < 16) resp[15 - i] = MISO;
      SCLK = 1'b1;
      if (perturb && i == 4) randomize_vals();
      wait_clk(HALF);
    end
    SS_n = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      wait_clk(1);
      if (k == 4) begin
        d4 = frm_done; e4 = frm_err; lc4 = last_chnnl;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    batt_val = '0; curr_val = '0; brake_val = '0; torque_val = '0;
    wait_clk(5);
    rst = 1'b0;
    model_reset();
    wait_clk(1);
    tests_run++; if (MISO !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b expected 0", MISO); end
    tests_run++; if (frm_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", frm_done); end
    tests_run++; if (frm_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", frm_err); end
    tests_run++; if (last_chnnl !== 3'd0) begin tests_failed++; $display("FAIL reset_chnnl: got %0d expected 0", last_chnnl); end
    tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_first_frame();
    logic [15:0] resp, exp;
    logic d, e;
    logic [2:0] lc;
    batt_val = 12'hABC;
    exp = m_resp();
    spi_frame(16'h0000, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'h0000, 16);
    tests_run++; if (resp !== exp) begin tests_failed++; $display("FAIL first_resp: got %h expected %h", resp, exp); end
    tests_run++; if (d !== 1'b1 || e !== 1'b0) begin tests_failed++; $display("FAIL first_pulse: done %b err %b expected 1 0", d, e); end
    tests_run++; if (lc !== 3'd0) begin tests_failed++; $display("FAIL first_chnnl: got %0d expected 0", lc); end
    tests_run++; if (MISO !== 1'b0) begin tests_failed++; $display("FAIL idle_miso: got %b expected 0", MISO); end
  endtask

  task automatic test_channel_seq();
    logic [15:0] cmds [4] = '{16'h0800, 16'h1800, 16'h2000, 16'h0000};
    logic [15:0] resp, exp;
    logic d, e;
    logic [2:0] lc;
    curr_val = 12'h123; brake_val = 12'h456; torque_val = 12'h789; batt_val = 12'hABC;
    for (int i = 0; i < 4; i++) begin
      exp = m_resp();
      spi_frame(cmds[i], 16, 8, 1'b0, resp, d, e, lc);
      model_frame(cmds[i], 16);
      tests_run++; if (resp !== exp) begin tests_failed++; $display("FAIL seq_resp[%0d]: got %h expected %h", i, resp, exp); end
      tests_run++; if (d !== 1'b1 || lc !== cmds[i][13:11]) begin tests_failed++; $display("FAIL seq_done[%0d]: done %b chnnl %0d expected 1 %0d", i, d, lc, cmds[i][13:11]); end
    end
  endtask

  task automatic test_unused_channel();
    logic [15:0] resp, exp;
    logic d, e;
    logic [2:0] lc;
    spi_frame(16'hF7FF, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'hF7FF, 16);
    tests_run++; if (lc !== 3'd6) begin tests_failed++; $display("FAIL unused_chnnl: got %0d expected 6", lc); end
    exp = m_resp();
    spi_frame(16'h0000, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'h0000, 16);
    tests_run++; if (resp !== exp || resp[15:2] !== 14'h0) begin tests_failed++; $display("FAIL unused_resp: got %h expected %h", resp, exp); end
  endtask

  task automatic test_bad_length();
    logic [15:0] resp, exp;
    logic d, e;
    logic [2:0] lc;
    int nb [2] = '{12, 18};
    spi_frame(16'h0800, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'h0800, 16);
    for (int i = 0; i < 2; i++) begin
      spi_frame(16'h2000, nb[i], 8, 1'b0, resp, d, e, lc);
      model_frame(16'h2000, nb[i]);
      tests_run++; if (d !== 1'b0 || e !== 1'b1) begin tests_failed++; $display("FAIL badlen_pulse[%0d]: done %b err %b expected 0 1", nb[i], d, e); end
      tests_run++; if (lc !== 3'd1) begin tests_failed++; $display("FAIL badlen_chnnl[%0d]: got %0d expected 1", nb[i], lc); end
    end
    curr_val = 12'h5A3;
    exp = m_resp();
    spi_frame(16'h0000, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'h0000, 16);
    tests_run++; if (resp !== exp) begin tests_failed++; $display("FAIL badlen_next: got %h expected %h", resp, exp); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] resp, exp;
    logic d, e;
    logic [2:0] lc;
    logic miso_seen;
    int d0, e0;
    spi_frame(16'h1800, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'h1800, 16);
    d0 = done_cnt; e0 = err_cnt;
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 7; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; wait_clk(HALF); SCLK = 1'b1; wait_clk(HALF);
    end
    rst = 1'b1;
    wait_clk(2);
    tests_run++; if (MISO !== 1'b0 || state_dbg !== 2'd0) begin tests_failed++; $display("FAIL rstmid_hold: miso %b state %0d expected 0 0", MISO, state_dbg); end
    rst = 1'b0;
    model_reset();
    miso_seen = 1'b0;
    for (int i = 7; i < 16; i++) begin
      SCLK = 1'b0; wait_clk(HALF); miso_seen |= MISO; SCLK = 1'b1; wait_clk(HALF);
    end
    SS_n = 1'b1;
    wait_clk(8);
    tests_run++; if (miso_seen !== 1'b0) begin tests_failed++; $display("FAIL rstmid_miso: got %b expected 0", miso_seen); end
    tests_run++; if (done_cnt != d0 || err_cnt != e0) begin tests_failed++; $display("FAIL rstmid_ignore: done %0d err %0d expected %0d %0d", done_cnt, err_cnt, d0, e0); end
    tests_run++; if (last_chnnl !== 3'd0) begin tests_failed++; $display("FAIL rstmid_chnnl: got %0d expected 0", last_chnnl); end
    batt_val = 12'h3C5; brake_val = 12'hFFF;
    exp = m_resp();
    spi_frame(16'h1800, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'h1800, 16);
    tests_run++; if (resp !== exp || d !== 1'b1) begin tests_failed++; $display("FAIL rstmid_next: resp %h done %b expected %h 1", resp, d, exp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] resp, exp;
    logic d, e;
    logic [2:0] lc;
    logic [15:0] cmd;
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      cmd = 16'($urandom_range(0, 65535));
      exp = m_resp();
      spi_frame(cmd, 16, (i == 3) ? 8 : 1, 1'b0, resp, d, e, lc);
      model_frame(cmd, 16);
      tests_run++; if (resp !== exp) begin tests_failed++; $display("FAIL b2b_resp[%0d]: got %h expected %h", i, resp, exp); end
    end
    tests_run++; if (done_cnt != d0 + 4 || last_chnnl !== m_ptr) begin tests_failed++; $display("FAIL b2b_done: count %0d chnnl %0d expected %0d %0d", done_cnt - d0, last_chnnl, 4, m_ptr); end
  endtask

  task automatic test_random();
    logic [15:0] resp, exp, cmd;
    logic d, e;
    logic [2:0] lc;
    int d0, e0;
    for (int i = 0; i < 24; i++) begin
      randomize_vals();
      cmd = 16'($urandom_range(0, 65535));
      exp = m_resp();
      d0 = done_cnt; e0 = err_cnt;
      spi_frame(cmd, 16, $urandom_range(5, 10), 1'b1, resp, d, e, lc);
      model_frame(cmd, 16);
      tests_run++; if (resp !== exp) begin tests_failed++; $display("FAIL rand_resp[%0d]: got %h expected %h", i, resp, exp); end
      tests_run++; if (d !== 1'b1 || lc !== cmd[13:11] || done_cnt != d0 + 1 || err_cnt != e0) begin
        tests_failed++; $display("FAIL rand_done[%0d]: done %b chnnl %0d count %0d expected 1 %0d 1", i, d, lc, done_cnt - d0, cmd[13:11]);
      end
    end
  endtask

`ifdef A2D_NOISE_EN
  task automatic test_noise();
    logic [15:0] resp, exp;
    logic d, e;
    logic [2:0] lc;
    batt_val = 12'h800;
    spi_frame(16'h0000, 16, 8, 1'b0, resp, d, e, lc);
    model_frame(16'h0000, 16);
    for (int i = 0; i < 2; i++) begin
      exp = m_resp();
      spi_frame(16'h0000, 16, 8, 1'b0, resp, d, e, lc);
      model_frame(16'h0000, 16);
      tests_run++; if (resp !== exp || resp[15:2] !== 14'h0200) begin tests_failed++; $display("FAIL noise_resp[%0d]: got %h expected %h", i, resp, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_channel_seq();
    test_unused_channel();
    test_bad_length();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef A2D_NOISE_EN
    test_noise();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
